// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one gate-level full adder, LSB first, start/busy/done handshake.
// Define BIT_SERIAL_ADDER_OVERFLOW_EN to add the registered signed-overflow output o_overflow.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic axb;
    logic ab;
    logic axb_c;

    xor g_x0 (axb, a, b);
    xor g_x1 (sum, axb, cin);
    and g_a0 (ab, a, b);
    and g_a1 (axb_c, axb, cin);
    or  g_o0 (cout, ab, axb_c);
endmodule

module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry_in,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry_out,
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
    output logic             o_overflow,
`endif
    output logic [1:0]       o_state
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Handshake: a start is accepted on a rising edge in IDLE or DONE; o_busy covers
    // the WIDTH RUN cycles and o_done pulses once when o_sum/o_carry_out are valid.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic            carry_q;
    logic            cout_reg;
    logic [CW-1:0]   count;
    logic            fa_sum;
    logic            fa_cout;
    logic            start_acc;
    logic            last_bit;

    assign start_acc = i_start && (state == S_IDLE || state == S_DONE);
    assign last_bit  = (state == S_RUN) && (count == LAST);

    full_adder u_fa (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_start) state_nxt = S_RUN;
            S_RUN:   if (last_bit) state_nxt = S_DONE;
            S_DONE:  state_nxt = i_start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy  = (state == S_RUN);
        o_done  = (state == S_DONE);
        o_state = state;
    end

    // Result registers only move on RUN edges, so they hold across the start edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            carry_q  <= 1'b0;
            cout_reg <= 1'b0;
            count    <= '0;
        end else if (start_acc) begin
            a_reg   <= i_a;
            b_reg   <= i_b;
            carry_q <= i_carry_in;
            count   <= '0;
        end else if (state == S_RUN) begin
            a_reg    <= a_reg >> 1;
            b_reg    <= b_reg >> 1;
            sum_reg  <= {fa_sum, sum_reg[WIDTH-1:1]};
            carry_q  <= fa_cout;
            cout_reg <= fa_cout;
            count    <= count + CW'(1);
        end
    end

`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
    logic ovf_reg;

    // carry_q during the MSB cycle is the carry into the MSB.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)       ovf_reg <= 1'b0;
        else if (last_bit) ovf_reg <= carry_q ^ fa_cout;
    end

    assign o_overflow = ovf_reg;
`endif

    assign o_sum       = sum_reg;
    assign o_carry_out = cout_reg;
endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed bench for bit_serial_adder: scoreboard queue filled at accepted starts,
// monitor pops and compares on every o_done.

module tb_bit_serial_adder;
    localparam int WIDTH = 8;

    logic             i_clk = 1'b0;
    logic             i_reset = 1'b1;
    logic             i_start = 1'b0;
    logic [WIDTH-1:0] i_a = '0;
    logic [WIDTH-1:0] i_b = '0;
    logic             i_carry_in = 1'b0;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_sum;
    logic             o_carry_out;
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
    logic             o_overflow;
`endif
    logic [1:0]       o_state;

    logic [9:0] exp_q[$];  // {overflow, carry_out, sum}
    int n_vec  = 0;
    int n_fail = 0;

    bit_serial_adder #(.WIDTH(WIDTH)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_carry_in  (i_carry_in),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_sum       (o_sum),
        .o_carry_out (o_carry_out),
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
        .o_overflow  (o_overflow),
`endif
        .o_state     (o_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge i_clk) begin
        logic [9:0] e;
        if (o_done) begin
            check("busy_at_done", 32'(o_busy), 32'd0);
            if (exp_q.size() == 0) begin
                check("done_without_start", 32'(o_done), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sum", 32'(o_sum), 32'(e[7:0]));
                check("carry_out", 32'(o_carry_out), 32'(e[8]));
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
                check("overflow", 32'(o_overflow), 32'(e[9]));
`endif
            end
        end
    end

    // Called at a negedge; the start is accepted at the following posedge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [9:0] exp);
        i_start = 1'b1;
        i_a = a;
        i_b = b;
        i_carry_in = cin;
        @(posedge i_clk);
        exp_q.push_back(exp);
        #1;
        i_start = 1'b0;
        i_a = '0;
        i_b = '0;
        i_carry_in = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int cyc = 0;
        int busy_cyc = 0;
        do begin
            @(negedge i_clk);
            cyc++;
            if (o_busy) busy_cyc++;
        end while (!o_done && cyc < 40);
        check({name, "_latency"}, 32'(cyc - 1), 32'(WIDTH));
        check({name, "_busy_cycles"}, 32'(busy_cyc), 32'(WIDTH));
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_busy"}, 32'(o_busy), 32'd0);
        check({name, "_done"}, 32'(o_done), 32'd0);
        check({name, "_sum"}, 32'(o_sum), 32'd0);
        check({name, "_cout"}, 32'(o_carry_out), 32'd0);
        check({name, "_state"}, 32'(o_state), 32'd0);
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
        check({name, "_ovf"}, 32'(o_overflow), 32'd0);
`endif
    endtask

    initial begin
        int dn;

        repeat (2) @(negedge i_clk);
        check_zero_outputs("reset");
        i_reset = 1'b0;
        @(negedge i_clk);

        issue(8'h5A, 8'h3C, 1'b0, {1'b1, 1'b0, 8'h96});
        wait_done("op_5a_3c");
        @(negedge i_clk);
        check("idle_after_done", 32'(o_state), 32'd0);

        issue(8'hFF, 8'h01, 1'b0, {1'b0, 1'b1, 8'h00});
        wait_done("op_ff_01");
        @(negedge i_clk);
        issue(8'hFF, 8'hFF, 1'b1, {1'b0, 1'b1, 8'hFF});
        wait_done("op_ff_ff_c");
        @(negedge i_clk);
        check("sum_holds_idle", 32'(o_sum), 32'h0FF);

        // Start held through RUN with different operands must be ignored.
        i_start = 1'b1;
        i_a = 8'h12;
        i_b = 8'h34;
        i_carry_in = 1'b0;
        @(posedge i_clk);
        exp_q.push_back({1'b0, 1'b0, 8'h46});
        #1;
        i_a = 8'h11;
        i_b = 8'h22;
        i_carry_in = 1'b1;
        fork
            wait_done("held_start");
            begin
                repeat (4) @(negedge i_clk);
                #1 i_start = 1'b0;
            end
        join
        @(negedge i_clk);

        // Back-to-back: second start issued during the DONE cycle.
        issue(8'h44, 8'h55, 1'b0, {1'b1, 1'b0, 8'h99});
        wait_done("op_44_55");
        issue(8'h01, 8'h02, 1'b0, {1'b0, 1'b0, 8'h03});
        wait_done("back_to_back");
        @(negedge i_clk);

        // Asynchronous reset in the 4th RUN cycle aborts the operation.
        i_start = 1'b1;
        i_a = 8'h33;
        i_b = 8'h44;
        @(posedge i_clk);
        #1 i_start = 1'b0;
        repeat (3) @(posedge i_clk);
        #3 i_reset = 1'b1;
        #1 check_zero_outputs("abort");
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        dn = 0;
        repeat (12) begin
            @(negedge i_clk);
            if (o_done) dn++;
        end
        check("no_done_after_abort", 32'(dn), 32'd0);

        issue(8'h10, 8'h20, 1'b0, {1'b0, 1'b0, 8'h30});
        wait_done("after_abort");
        @(negedge i_clk);

`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
        issue(8'h7F, 8'h01, 1'b0, {1'b1, 1'b0, 8'h80});
        wait_done("ovf_7f_01");
        @(negedge i_clk);
        issue(8'hFF, 8'h01, 1'b0, {1'b0, 1'b1, 8'h00});
        wait_done("ovf_ff_01");
        @(negedge i_clk);
        issue(8'h80, 8'h80, 1'b0, {1'b1, 1'b1, 8'h00});
        wait_done("ovf_80_80");
        @(negedge i_clk);
`endif

        repeat (3) @(negedge i_clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
